// File: rtl/match_game_ctrl.sv
// In-game controller for the tile-matching game: cursor moves, tile flips, timed show, compare, score.
// Optional attempt limit is compiled in when the MOVE_LIMIT_EN macro is defined.
module match_game_ctrl #(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int DATA_W      = 8,
  parameter int RD_LAT      = 2,
  parameter int SHOW_CYCLES = 100_000_000,
  parameter int SCORE_W     = 8,
  parameter int MAX_MOVES   = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              game_on,
  input  logic                              user_quit,
  input  logic                              btn_up,
  input  logic                              btn_down,
  input  logic                              btn_left,
  input  logic                              btn_right,
  input  logic                              btn_select,
  output logic [$clog2(ROWS*COLS)-1:0]      mem_addr,
  output logic                              mem_we,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic [DATA_W-1:0]                 mem_rdata,
  output logic [SCORE_W-1:0]                score,
  output logic [$clog2(ROWS*COLS/2):0]      pairs,
  output logic                              game_over,
  output logic                              win,
  output logic [3:0]                        state_dbg
);

  localparam int NT = ROWS * COLS;
  localparam int NP = NT / 2;
  localparam int AW = $clog2(NT);
  localparam int PW = $clog2(NP) + 1;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int IW = DATA_W - 2;
  localparam int LW = $clog2(RD_LAT + 1);
  localparam int SW = $clog2(SHOW_CYCLES + 1);

`ifdef MOVE_LIMIT_EN
  localparam logic LIMIT_ON = 1'b1;
`else
  localparam logic LIMIT_ON = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    SELECT  = 4'd1,
    MOVE    = 4'd2,
    FLIP    = 4'd3,
    SHOW    = 4'd4,
    COMPARE = 4'd5,
    HIDE    = 4'd6,
    DONE    = 4'd7
  } state_t;

  state_t              state, state_n;
  logic [1:0]          phase, phase_n;
  logic [LW-1:0]       wait_cnt, wait_n;
  logic [SW-1:0]       show_cnt, show_n;
  logic [RW-1:0]       cur_row, cur_row_n, tgt_row, tgt_row_n;
  logic [CW-1:0]       cur_col, cur_col_n, tgt_col, tgt_col_n;
  logic [AW-1:0]       first_addr, first_addr_n, second_addr, second_addr_n;
  logic [IW-1:0]       first_id, first_id_n, second_id, second_id_n;
  logic                have_first, have_first_n;
  logic [SCORE_W-1:0]  score_n, score_inc;
  logic [PW-1:0]       pairs_n, pairs_inc;
  logic [AW-1:0]       addr_n, cur_addr, tgt_addr;
  logic                we_n;
  logic [DATA_W-1:0]   wdata_n;
  logic [4:0]          btn_now, btn_prev, btn_edge;
  logic                rd_ready, limit_hit;

  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] r, input logic [CW-1:0] c);
    return AW'(r) * AW'(COLS) + AW'(c);
  endfunction

  assign btn_now   = {btn_select, btn_up, btn_down, btn_left, btn_right};
  assign btn_edge  = btn_now & ~btn_prev;
  assign cur_addr  = cell_addr(cur_row, cur_col);
  assign tgt_addr  = cell_addr(tgt_row, tgt_col);
  assign rd_ready  = (wait_cnt == LW'(0));
  assign score_inc = (score == {SCORE_W{1'b1}}) ? score : score + SCORE_W'(1);
  assign pairs_inc = (pairs == PW'(NP)) ? pairs : pairs + PW'(1);
  assign limit_hit = LIMIT_ON && (score_inc == SCORE_W'(MAX_MOVES));
  assign state_dbg = state;

  // Next-state and datapath decisions; memory interface values are registered below.
  always_comb begin
    state_n       = state;
    phase_n       = phase;
    wait_n        = wait_cnt;
    show_n        = show_cnt;
    cur_row_n     = cur_row;
    cur_col_n     = cur_col;
    tgt_row_n     = tgt_row;
    tgt_col_n     = tgt_col;
    first_addr_n  = first_addr;
    first_id_n    = first_id;
    second_addr_n = second_addr;
    second_id_n   = second_id;
    have_first_n  = have_first;
    score_n       = score;
    pairs_n       = pairs;
    addr_n        = mem_addr;
    we_n          = 1'b0;
    wdata_n       = mem_wdata;
    if (user_quit || !game_on) begin
      // Abandon whatever is in flight; the loader rebuilds the board.
      state_n      = IDLE;
      phase_n      = 2'd0;
      score_n      = '0;
      pairs_n      = '0;
      cur_row_n    = '0;
      cur_col_n    = '0;
      have_first_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          score_n       = '0;
          pairs_n       = '0;
          cur_row_n     = '0;
          cur_col_n     = '0;
          first_addr_n  = '0;
          second_addr_n = '0;
          first_id_n    = '0;
          second_id_n   = '0;
          have_first_n  = 1'b0;
          phase_n       = 2'd0;
          state_n       = SELECT;
        end
        SELECT: begin
          phase_n   = 2'd0;
          tgt_row_n = cur_row;
          tgt_col_n = cur_col;
          if (btn_edge[4]) begin
            state_n = FLIP;
          end else if (btn_edge[3]) begin
            tgt_row_n = (cur_row == RW'(0)) ? RW'(ROWS - 1) : cur_row - RW'(1);
            state_n   = MOVE;
          end else if (btn_edge[2]) begin
            tgt_row_n = (cur_row == RW'(ROWS - 1)) ? RW'(0) : cur_row + RW'(1);
            state_n   = MOVE;
          end else if (btn_edge[1]) begin
            tgt_col_n = (cur_col == CW'(0)) ? CW'(COLS - 1) : cur_col - CW'(1);
            state_n   = MOVE;
          end else if (btn_edge[0]) begin
            tgt_col_n = (cur_col == CW'(COLS - 1)) ? CW'(0) : cur_col + CW'(1);
            state_n   = MOVE;
          end else begin
            state_n = SELECT;
          end
        end
        MOVE: begin
          case (phase)
            2'd0: begin
              addr_n  = cur_addr;
              wait_n  = LW'(RD_LAT);
              phase_n = 2'd1;
            end
            2'd1: begin
              if (!rd_ready) begin
                wait_n = wait_cnt - LW'(1);
              end else begin
                we_n    = 1'b1;
                wdata_n = {mem_rdata[DATA_W-1:1], 1'b0};
                phase_n = 2'd2;
              end
            end
            2'd2: begin
              cur_row_n = tgt_row;
              cur_col_n = tgt_col;
              addr_n    = tgt_addr;
              wait_n    = LW'(RD_LAT);
              phase_n   = 2'd3;
            end
            default: begin
              if (!rd_ready) begin
                wait_n = wait_cnt - LW'(1);
              end else begin
                we_n    = 1'b1;
                wdata_n = {mem_rdata[DATA_W-1:1], 1'b1};
                phase_n = 2'd0;
                state_n = SELECT;
              end
            end
          endcase
        end
        FLIP: begin
          if (phase == 2'd0) begin
            addr_n  = cur_addr;
            wait_n  = LW'(RD_LAT);
            phase_n = 2'd1;
          end else if (!rd_ready) begin
            wait_n = wait_cnt - LW'(1);
          end else begin
            phase_n = 2'd0;
            if (mem_rdata[1]) begin
              // Face-up or already matched: nothing to do.
              state_n = SELECT;
            end else begin
              we_n    = 1'b1;
              wdata_n = {mem_rdata[DATA_W-1:2], 1'b1, mem_rdata[0]};
              if (!have_first) begin
                first_addr_n = mem_addr;
                first_id_n   = mem_rdata[DATA_W-1:2];
                have_first_n = 1'b1;
                state_n      = SELECT;
              end else begin
                second_addr_n = mem_addr;
                second_id_n   = mem_rdata[DATA_W-1:2];
                show_n        = SW'(SHOW_CYCLES - 1);
                state_n       = SHOW;
              end
            end
          end
        end
        SHOW: begin
          if (show_cnt == SW'(0)) begin
            state_n = COMPARE;
          end else begin
            show_n = show_cnt - SW'(1);
          end
        end
        COMPARE: begin
          score_n      = score_inc;
          have_first_n = 1'b0;
          phase_n      = 2'd0;
          if (first_id == second_id) begin
            pairs_n = pairs_inc;
            if (pairs_inc == PW'(NP)) begin
              state_n = DONE;
            end else if (limit_hit) begin
              state_n = DONE;
            end else begin
              state_n = SELECT;
            end
          end else if (limit_hit) begin
            state_n = DONE;
          end else begin
            state_n = HIDE;
          end
        end
        HIDE: begin
          we_n = 1'b1;
          if (phase == 2'd0) begin
            addr_n  = first_addr;
            wdata_n = {first_id, 1'b0, (first_addr == cur_addr)};
            phase_n = 2'd1;
          end else begin
            addr_n  = second_addr;
            wdata_n = {second_id, 1'b0, (second_addr == cur_addr)};
            phase_n = 2'd0;
            state_n = SELECT;
          end
        end
        DONE: begin
          state_n = DONE;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  // State register, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      phase       <= 2'd0;
      wait_cnt    <= '0;
      show_cnt    <= '0;
      cur_row     <= '0;
      cur_col     <= '0;
      tgt_row     <= '0;
      tgt_col     <= '0;
      first_addr  <= '0;
      first_id    <= '0;
      second_addr <= '0;
      second_id   <= '0;
      have_first  <= 1'b0;
      btn_prev    <= 5'b00000;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      score       <= '0;
      pairs       <= '0;
      game_over   <= 1'b0;
      win         <= 1'b0;
    end else begin
      state       <= state_n;
      phase       <= phase_n;
      wait_cnt    <= wait_n;
      show_cnt    <= show_n;
      cur_row     <= cur_row_n;
      cur_col     <= cur_col_n;
      tgt_row     <= tgt_row_n;
      tgt_col     <= tgt_col_n;
      first_addr  <= first_addr_n;
      first_id    <= first_id_n;
      second_addr <= second_addr_n;
      second_id   <= second_id_n;
      have_first  <= have_first_n;
      btn_prev    <= btn_now;
      mem_addr    <= addr_n;
      mem_we      <= we_n;
      mem_wdata   <= wdata_n;
      score       <= score_n;
      pairs       <= pairs_n;
      game_over   <= (state_n == DONE);
      win         <= (state_n == DONE) && (pairs_n == PW'(NP));
    end
  end

endmodule
